// File: rtl/fifo_ctl.sv
// Synchronous FIFO controller driving an external single-port combinational-read RAM,
// with a registered pop stage. Define FIFO_CTL_BYPASS_EN to let words skip the RAM when it is empty.
module fifo_ctl #(
  parameter int unsigned DWIDTH = 16,
  parameter int unsigned AWIDTH = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DWIDTH-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic              ram_we,
  output logic [AWIDTH-1:0] ram_addr,
  output logic [DWIDTH-1:0] ram_wdata,
  input  logic [DWIDTH-1:0] ram_rdata,
  output logic [AWIDTH:0]   count
);

  localparam logic [AWIDTH:0] L_DEPTH = {1'b1, {AWIDTH{1'b0}}};

  logic [AWIDTH-1:0] r_wr_ptr;
  logic [AWIDTH-1:0] r_rd_ptr;
  logic [AWIDTH:0]   r_ram_cnt;
  logic              r_out_valid;
  logic [DWIDTH-1:0] r_out_data;

  logic w_slot_free;
  logic w_ram_empty;
  logic w_ram_full;
  logic w_read_cyc;
  logic w_bypass_cyc;
  logic w_in_ready;
  logic w_push;
  logic w_pop;
  logic w_ram_write;

  always_comb begin
    w_slot_free = !r_out_valid || out_ready;
    w_ram_empty = (r_ram_cnt == '0);
    w_ram_full  = (r_ram_cnt == L_DEPTH);
    // The single RAM port serves a read first; a competing write is retried next cycle.
    w_read_cyc  = !w_ram_empty && w_slot_free;
  end

`ifdef FIFO_CTL_BYPASS_EN
  always_comb w_bypass_cyc = w_ram_empty && w_slot_free && in_valid;
`else
  always_comb w_bypass_cyc = 1'b0;
`endif

  always_comb begin
    w_in_ready  = (!w_read_cyc && !w_ram_full) || w_bypass_cyc;
    w_push      = in_valid && w_in_ready;
    w_pop       = r_out_valid && out_ready;
    w_ram_write = w_push && !w_bypass_cyc;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ram_cnt   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_read_cyc) begin
        r_out_data  <= ram_rdata;
        r_out_valid <= 1'b1;
        r_rd_ptr    <= r_rd_ptr + AWIDTH'(1);
        r_ram_cnt   <= r_ram_cnt - (AWIDTH+1)'(1);
      end else if (w_bypass_cyc) begin
        r_out_data  <= in_data;
        r_out_valid <= 1'b1;
      end else begin
        if (w_pop) begin
          r_out_valid <= 1'b0;
        end
        if (w_ram_write) begin
          r_wr_ptr  <= r_wr_ptr + AWIDTH'(1);
          r_ram_cnt <= r_ram_cnt + (AWIDTH+1)'(1);
        end
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign ram_we    = w_ram_write;
  assign ram_addr  = w_read_cyc ? r_rd_ptr : r_wr_ptr;
  assign ram_wdata = in_data;
  assign count     = r_ram_cnt + {{AWIDTH{1'b0}}, r_out_valid};

endmodule

// File: tb/tb_fifo_ctl.sv
// Self-checking bench for fifo_ctl: queue-based reference model, directed scenarios, random traffic.
module tb_fifo_ctl;

  localparam int DW    = 16;
  localparam int AW    = 3;
  localparam int DEPTH = 1 << AW;
`ifdef FIFO_CTL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic [AW:0]   count;

  fifo_ctl #(.DWIDTH(DW), .AWIDTH(AW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .count(count)
  );

  always #5 clk = ~clk;

  // Attached single-port RAM: combinational read, write on rising edge.
  logic [DW-1:0] mem [DEPTH];
  assign ram_rdata = mem[ram_addr];
  always @(posedge clk) if (ram_we) mem[ram_addr] <= ram_wdata;

  int we_cnt = 0;
  always @(posedge clk) if (ram_we) we_cnt <= we_cnt + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: words waiting in RAM as a queue, plus the output slot.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sent[$];
  bit            m_ov;
  logic [DW-1:0] m_od;
  int            n_popped;

  task automatic model_reset();
    mq.delete();
    sent.delete();
    m_ov = 1'b0;
    m_od = '0;
  endtask

  // Called at posedge+1; drives one cycle, checks, advances the model, returns at next posedge+1.
  task automatic step(input bit iv, input logic [DW-1:0] id, input bit ordy, output bit acc);
    bit sf, rd, byp, ir, push, pop;
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    #2;
    sf   = !m_ov || ordy;
    rd   = (mq.size() != 0) && sf;
    byp  = BYP && (mq.size() == 0) && sf && iv;
    ir   = (!rd && (mq.size() < DEPTH)) || byp;
    push = iv && ir;
    pop  = m_ov && ordy;
    check("in_ready", {31'd0, in_ready}, {31'd0, ir});
    check("ram_we", {31'd0, ram_we}, {31'd0, push && !byp});
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("count", 32'(count), 32'(mq.size()) + 32'(m_ov));
    if (m_ov) check("out_data", 32'(out_data), 32'(m_od));
    if (push && !byp) check("ram_wdata", 32'(ram_wdata), 32'(id));
    if (pop) begin
      n_popped++;
      if (sent.size() == 0) check("order_underflow", 32'(out_data), 32'hDEAD_0000);
      else check("order", 32'(out_data), 32'(sent.pop_front()));
    end
    if (push) sent.push_back(id);
    if (rd) begin
      m_od = mq.pop_front();
      m_ov = 1'b1;
    end else if (byp) begin
      m_od = id;
      m_ov = 1'b1;
    end else if (pop) begin
      m_ov = 1'b0;
    end
    if (push && !byp) mq.push_back(id);
    acc = push;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] id, input bit ordy);
    bit acc;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) step(1'b1, id, ordy, acc);
    if (!acc) check("push_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit acc;
    for (int t = 0; t < 40 && (m_ov || mq.size() != 0); t++) step(1'b0, '0, 1'b1, acc);
    check("drain_empty", 32'(count), 32'd0);
  endtask

  initial begin
    bit acc;
    int we0;
    logic [DW-1:0] nxt;
    reset = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    model_reset();
    n_popped = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", 32'(count), 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_ram_addr", 32'(ram_addr), 32'd0);
    reset = 1'b0;

    // Reset then idle
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, acc);
    check("idle_out_data", 32'(out_data), 32'd0);
    check("idle_ram_we", {31'd0, ram_we}, 32'd0);

    // Single word into empty FIFO
    we0 = we_cnt;
    step(1'b1, 16'h1234, 1'b0, acc);
    check("byp_acc", {31'd0, acc}, 32'd1);
    check("byp_ov_1cyc", {31'd0, out_valid}, {31'd0, BYP});
    step(1'b0, '0, 1'b0, acc);
    check("byp_ov_2cyc", {31'd0, out_valid}, 32'd1);
    check("byp_data", 32'(out_data), 32'h1234);
    check("byp_count", 32'(count), 32'd1);
    check("byp_we_pulses", 32'(we_cnt - we0), BYP ? 32'd0 : 32'd1);
    drain();

    // Fill to capacity, then the tenth push must stall
    for (int w = 1; w <= DEPTH + 1; w++) push_word(DW'(w), 1'b0);
    step(1'b0, '0, 1'b0, acc);
    check("full_count", 32'(count), 32'(DEPTH + 1));
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 16'h000A, 1'b0, acc);
      check("full_stall", {31'd0, acc}, 32'd0);
    end

    // Drain from full while pushing 0x000A..0x0010, across pointer wrap
    n_popped = 0;
    nxt = 16'h000A;
    for (int t = 0; t < 200 && (n_popped < 16); t++) begin
      step(nxt <= 16'h0010, nxt, 1'b1, acc);
      if (acc) nxt++;
    end
    check("drain_popped", 32'(n_popped), 32'd16);
    check("drain_pushed", 32'(nxt), 32'h0011);
    drain();

    // Contention: ram holds 3, output valid, push and pop together
    for (int w = 0; w < 4; w++) push_word(DW'(16'h0100 + w), 1'b0);
    step(1'b0, '0, 1'b0, acc);
    check("cont_setup", 32'(mq.size()), 32'd3);
    in_valid = 1'b1; in_data = 16'h0200; out_ready = 1'b1;
    #2;
    check("cont_ram_we", {31'd0, ram_we}, 32'd0);
    check("cont_in_ready", {31'd0, in_ready}, 32'd0);
    check("cont_addr_rd", 32'(ram_addr), 32'(dut.r_rd_ptr));
    step(1'b1, 16'h0200, 1'b1, acc);
    check("cont_no_acc", {31'd0, acc}, 32'd0);
    step(1'b1, 16'h0200, 1'b0, acc);
    check("cont_retry_acc", {31'd0, acc}, 32'd1);
    drain();

    // Async reset with count=5 mid-pop
    for (int w = 0; w < 5; w++) push_word(DW'(16'h0300 + w), 1'b0);
    check("arst_pre_count", 32'(count), 32'd5);
    in_valid = 1'b0; out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    check("arst_count", 32'(count), 32'd0);
    check("arst_out_valid", {31'd0, out_valid}, 32'd0);
    check("arst_out_data", 32'(out_data), 32'd0);
    check("arst_in_ready", {31'd0, in_ready}, 32'd1);
    check("arst_ram_we", {31'd0, ram_we}, 32'd0);
    check("arst_ram_addr", 32'(ram_addr), 32'd0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
    push_word(16'hBEEF, 1'b0);
    step(1'b0, '0, 1'b0, acc);
    check("arst_first_word", 32'(out_data), 32'hBEEF);
    drain();

    // Random traffic with varying push/pop pressure
    for (int ph = 0; ph < 4; ph++) begin
      for (int t = 0; t < 400; t++) begin
        bit iv, ordy;
        iv   = ($urandom_range(3) < ((ph == 1) ? 1 : 3));
        ordy = ($urandom_range(3) < ((ph == 2) ? 1 : 2 + (ph & 1)));
        step(iv, DW'($urandom), ordy, acc);
      end
    end
    drain();

    in_valid = 1'b0; out_ready = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
